// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : pipe_pkg                                                        |
// | Brief    : Constants shared by the fetch/decode pipeline blocks.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_id_queue                                                     |
// | Brief    : In-order {pc, instr} queue between fetch and decode with flush. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module if_id_queue
    import pipe_pkg::*;
#(
    parameter int          DEPTH = 2,
    parameter int          AW    = 1,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc4,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    // in_ready depends on registered count only, so fetch never sees out_ready
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign w_head    = r_mem[r_rd_ptr];

    assign out_pc    = out_valid ? w_head[63:32] : 32'h0;
    assign out_instr = out_valid ? w_head[31:0]  : NOP;
    assign out_pc4   = out_pc + PC_STEP;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : if_id_queue
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_if_id_queue                                                  |
// | Brief    : Directed self-checking bench for if_id_queue (DEPTH=2).         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    if_id_queue #(.DEPTH(2), .AW(1), .NOP(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_count",     {30'b0, count}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        check("rst_out_pc",    out_pc, 32'h0);
        check("rst_out_pc4",   out_pc4, 32'h4);

        // single word: no bypass, visible next cycle, then popped
        drive(1'b1, 32'h0040_0000, 32'h2008_0005, 1'b1, 1'b0);
        check("nobypass_valid", {31'b0, out_valid}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_pc",    out_pc, 32'h0040_0000);
        check("single_pc4",   out_pc4, 32'h0040_0004);
        check("single_instr", out_instr, 32'h2008_0005);
        tick();
        check("single_popped", {30'b0, count}, 32'd0);
        check("single_empty_instr", out_instr, 32'h0);

        // fill while decode stalled; third word must be ignored
        drive(1'b1, 32'h0040_0000, 32'hA000_0000, 1'b0, 1'b0);
        tick();
        check("fill1_count", {30'b0, count}, 32'd1);
        drive(1'b1, 32'h0040_0004, 32'hA000_0001, 1'b0, 1'b0);
        tick();
        check("fill2_count",    {30'b0, count}, 32'd2);
        check("fill2_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h0040_0008, 32'hA000_0002, 1'b0, 1'b0);
        tick();
        check("full_ignore_count", {30'b0, count}, 32'd2);
        check("full_head_pc",      out_pc, 32'h0040_0000);
        check("full_head_instr",   out_instr, 32'hA000_0000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("drain1_pc",    out_pc, 32'h0040_0004);
        check("drain1_instr", out_instr, 32'hA000_0001);
        check("drain1_count", {30'b0, count}, 32'd1);

        // refill, then full + pop + in_valid: pop only, push next cycle
        drive(1'b1, 32'h0040_0008, 32'hA000_0002, 1'b0, 1'b0);
        tick();
        check("refill_count", {30'b0, count}, 32'd2);
        drive(1'b1, 32'h0040_000C, 32'hA000_0003, 1'b1, 1'b0);
        tick();
        check("fullpop_count", {30'b0, count}, 32'd1);
        check("fullpop_head",  out_pc, 32'h0040_0008);
        drive(1'b1, 32'h0040_000C, 32'hA000_0003, 1'b0, 1'b0);
        tick();
        check("afterpop_push_count", {30'b0, count}, 32'd2);
        check("afterpop_head",       out_pc, 32'h0040_0008);

        // flush with push and pop requested
        drive(1'b1, 32'h0040_0010, 32'hA000_0004, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_count",     {30'b0, count}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_out_instr", out_instr, 32'h0);
        check("flush_out_pc",    out_pc, 32'h0);
        drive(1'b1, 32'h0040_0040, 32'hB000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("postflush_valid", {31'b0, out_valid}, 32'd1);
        check("postflush_pc",    out_pc, 32'h0040_0040);
        check("postflush_instr", out_instr, 32'hB000_0000);
        check("postflush_count", {30'b0, count}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("postflush_drain", {30'b0, count}, 32'd0);

        // streaming push+pop: pointers wrap, count stays 1
        drive(1'b1, 32'h0040_0000, 32'hC000_0000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(i < 7, 32'h0040_0000 + 32'(4 * (i + 1)), 32'hC000_0000 + 32'(i + 1),
                  1'b1, 1'b0);
            check("stream_pc",    out_pc, 32'h0040_0000 + 32'(4 * i));
            check("stream_instr", out_instr, 32'hC000_0000 + 32'(i));
            check("stream_count", {30'b0, count}, 32'd1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("stream_end_count", {30'b0, count}, 32'd0);

        // pc4 wraps at 32 bits
        drive(1'b1, 32'hFFFF_FFFC, 32'hD000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0100, 32'hD000_0001, 1'b0, 1'b0);
        check("wrap_pc",  out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", out_pc4, 32'h0000_0000);
        tick();
        check("prerst_count", {30'b0, count}, 32'd2);

        // reset mid-operation leaves nothing visible
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_count",     {30'b0, count}, 32'd0);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready",  {31'b0, in_ready}, 32'd1);
        check("midrst_out_instr", out_instr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_if_id_queue
`default_nettype wire
